// File: rtl/multicycle_main_fsm.sv
// Main control FSM of the multi-cycle RISC-V core: sequences fetch/decode/execute/memory/writeback.
// Optional MULTICYCLE_MAIN_FSM_TRAP_EN builds a TRAP state that halts on unknown opcodes.
module multicycle_main_fsm #(
  parameter int COUNT_WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic [6:0]             op,
  input  logic                   mem_ready,
  output logic                   branch,
  output logic                   pc_update,
  output logic                   reg_write,
  output logic                   mem_write,
  output logic                   ir_write,
  output logic                   adr_src,
  output logic [1:0]             alu_src_a,
  output logic [1:0]             alu_src_b,
  output logic [1:0]             result_src,
  output logic [1:0]             alu_op,
  output logic                   illegal_instr,
  output logic [3:0]             state_o,
  output logic [COUNT_WIDTH-1:0] instr_count
);

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECUTER = 4'd6,
    EXECUTEI = 4'd7,
    ALUWB    = 4'd8,
    BEQ      = 4'd9,
    JAL      = 4'd10,
    TRAP     = 4'd11
  } state_t;

  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_RTYP = 7'b0110011;
  localparam logic [6:0] OP_ITYP = 7'b0010011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;

  state_t state, next_state;

  // NOTE: every signal driven in always_comb gets a default first so no latch is inferred.
  always_comb begin
    next_state = state;
    case (state)
      FETCH:    if (mem_ready) next_state = DECODE;
      DECODE: begin
        case (op)
          OP_LW, OP_SW: next_state = MEMADR;
          OP_RTYP:      next_state = EXECUTER;
          OP_ITYP:      next_state = EXECUTEI;
          OP_JAL:       next_state = JAL;
          OP_BEQ:       next_state = BEQ;
`ifdef MULTICYCLE_MAIN_FSM_TRAP_EN
          default:      next_state = TRAP;
`else
          default:      next_state = FETCH;
`endif
        endcase
      end
      MEMADR:   next_state = (op == OP_LW) ? MEMREAD : MEMWRITE;
      MEMREAD:  if (mem_ready) next_state = MEMWB;
      MEMWB:    next_state = FETCH;
      MEMWRITE: if (mem_ready) next_state = FETCH;
      EXECUTER: next_state = ALUWB;
      EXECUTEI: next_state = ALUWB;
      ALUWB:    next_state = FETCH;
      BEQ:      next_state = FETCH;
      JAL:      next_state = ALUWB;
`ifdef MULTICYCLE_MAIN_FSM_TRAP_EN
      TRAP:     next_state = TRAP;
`endif
      default:  next_state = FETCH;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state       <= FETCH;
      instr_count <= '0;
    end else begin
      state <= next_state;
      // Retirement is any return to FETCH from elsewhere; TRAP never returns, so never counts.
      if (next_state == FETCH && state != FETCH)
        instr_count <= instr_count + COUNT_WIDTH'(1);
    end
  end

  // Outputs decode the current state directly so the datapath sees them in the same cycle;
  // the fetch strobes are also gated by resetn so nothing fires while reset is held.
  always_comb begin
    branch     = 1'b0;
    pc_update  = 1'b0;
    reg_write  = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    adr_src    = 1'b0;
    alu_src_a  = 2'b00;
    alu_src_b  = 2'b00;
    result_src = 2'b00;
    alu_op     = 2'b00;
    case (state)
      FETCH: begin
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        ir_write   = mem_ready & resetn;
        pc_update  = mem_ready & resetn;
      end
      DECODE: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
      end
      MEMADR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
      end
      MEMREAD:  adr_src = 1'b1;
      MEMWB: begin
        result_src = 2'b01;
        reg_write  = 1'b1;
      end
      MEMWRITE: begin
        adr_src   = 1'b1;
        mem_write = 1'b1;
      end
      EXECUTER: begin
        alu_src_a = 2'b10;
        alu_op    = 2'b10;
      end
      EXECUTEI: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        alu_op    = 2'b10;
      end
      ALUWB:    reg_write = 1'b1;
      BEQ: begin
        alu_src_a = 2'b10;
        alu_op    = 2'b01;
        branch    = 1'b1;
      end
      JAL: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b10;
        pc_update = 1'b1;
      end
      default: ;
    endcase
  end

`ifdef MULTICYCLE_MAIN_FSM_TRAP_EN
  assign illegal_instr = (state == TRAP);
`else
  assign illegal_instr = 1'b0;
`endif

  assign state_o = state;

endmodule

// File: tb/tb_multicycle_main_fsm.sv
// Self-checking bench for multicycle_main_fsm: directed test-plan cases plus randomized
// instruction streams checked against a per-opcode phase-list model.
module tb_multicycle_main_fsm;

  localparam int CW = 4;
  localparam int S_FETCH = 0, S_DECODE = 1, S_MEMADR = 2, S_MEMREAD = 3, S_MEMWB = 4,
                 S_MEMWRITE = 5, S_EXECUTER = 6, S_EXECUTEI = 7, S_ALUWB = 8,
                 S_BEQ = 9, S_JAL = 10, S_TRAP = 11;

  typedef int phase_q_t[$];

  logic          clk = 1'b0;
  logic          resetn;
  logic [6:0]    op;
  logic          mem_ready;
  logic          branch, pc_update, reg_write, mem_write, ir_write, adr_src, illegal_instr;
  logic [1:0]    alu_src_a, alu_src_b, result_src, alu_op;
  logic [3:0]    state_o;
  logic [CW-1:0] instr_count;

  int checks = 0;
  int errors = 0;
  int exp_count = 0;
  bit rdy_random = 1'b0;
  bit ready_q[$];

  multicycle_main_fsm #(.COUNT_WIDTH(CW)) dut (
    .clk(clk), .resetn(resetn), .op(op), .mem_ready(mem_ready),
    .branch(branch), .pc_update(pc_update), .reg_write(reg_write), .mem_write(mem_write),
    .ir_write(ir_write), .adr_src(adr_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .result_src(result_src), .alu_op(alu_op), .illegal_instr(illegal_instr),
    .state_o(state_o), .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Phase list an instruction walks through, in the order the datapath needs it.
  function automatic phase_q_t phases_for(input logic [6:0] opc);
    phase_q_t q;
    case (opc)
      7'b0000011: q = '{S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB};
      7'b0100011: q = '{S_FETCH, S_DECODE, S_MEMADR, S_MEMWRITE};
      7'b0110011: q = '{S_FETCH, S_DECODE, S_EXECUTER, S_ALUWB};
      7'b0010011: q = '{S_FETCH, S_DECODE, S_EXECUTEI, S_ALUWB};
      7'b1101111: q = '{S_FETCH, S_DECODE, S_JAL, S_ALUWB};
      7'b1100011: q = '{S_FETCH, S_DECODE, S_BEQ};
`ifdef MULTICYCLE_MAIN_FSM_TRAP_EN
      default:    q = '{S_FETCH, S_DECODE, S_TRAP};
`else
      default:    q = '{S_FETCH, S_DECODE};
`endif
    endcase
    return q;
  endfunction

  // Expected control word {branch,pc_update,reg_write,mem_write,ir_write,adr_src,
  // alu_src_a,alu_src_b,result_src,alu_op,illegal_instr} for a phase.
  function automatic logic [14:0] exp_outs(input int st, input logic rdy);
    logic br, pcu, rw, mw, irw, adr, ill;
    logic [1:0] sa, sb, rs, ao;
    {br, pcu, rw, mw, irw, adr, ill} = '0;
    {sa, sb, rs, ao} = '0;
    case (st)
      S_FETCH:    begin sb = 2'b10; rs = 2'b10; irw = rdy; pcu = rdy; end
      S_DECODE:   begin sa = 2'b01; sb = 2'b01; end
      S_MEMADR:   begin sa = 2'b10; sb = 2'b01; end
      S_MEMREAD:  adr = 1'b1;
      S_MEMWB:    begin rs = 2'b01; rw = 1'b1; end
      S_MEMWRITE: begin adr = 1'b1; mw = 1'b1; end
      S_EXECUTER: begin sa = 2'b10; ao = 2'b10; end
      S_EXECUTEI: begin sa = 2'b10; sb = 2'b01; ao = 2'b10; end
      S_ALUWB:    rw = 1'b1;
      S_BEQ:      begin sa = 2'b10; ao = 2'b01; br = 1'b1; end
      S_JAL:      begin sa = 2'b01; sb = 2'b10; pcu = 1'b1; end
      S_TRAP:     ill = 1'b1;
      default:    ;
    endcase
    return {br, pcu, rw, mw, irw, adr, sa, sb, rs, ao, ill};
  endfunction

  function automatic logic next_ready();
    if (ready_q.size() > 0) return ready_q.pop_front();
    if (rdy_random) return ($urandom_range(0, 3) != 0);
    return 1'b1;
  endfunction

  function automatic logic [14:0] dut_outs();
    return {branch, pc_update, reg_write, mem_write, ir_write, adr_src,
            alu_src_a, alu_src_b, result_src, alu_op, illegal_instr};
  endfunction

  task automatic do_reset();
    @(negedge clk);
    resetn = 1'b0;
    mem_ready = 1'b1;
    #1;
    check("rst_state", state_o, S_FETCH);
    check("rst_count", instr_count, 0);
    check("rst_outs", dut_outs(), exp_outs(S_FETCH, 1'b0));
    @(negedge clk);
    mem_ready = 1'b0;
    resetn = 1'b1;
    exp_count = 0;
  endtask

  // Runs one instruction through the DUT, checking every cycle. abort_st >= 0 pulses
  // resetn while in that phase. trapped reports that the instruction ended in TRAP.
  task automatic run_instr(input logic [6:0] opc, input int abort_st,
                           output int cycles, output bit trapped);
    phase_q_t seq = phases_for(opc);
    int idx = 0;
    int trap_cycles = 0;
    int n = 0;
    bit done = 1'b0;
    int st;
    cycles = 0;
    trapped = 1'b0;
    while (!done && n < 100) begin
      n++;
      @(negedge clk);
      st = seq[idx];
      op = (st == S_DECODE || st == S_MEMADR) ? opc : 7'($urandom);
      mem_ready = next_ready();
      #1;
      check("state", state_o, st);
      check("outs", dut_outs(), exp_outs(st, mem_ready));
      check("count", instr_count, exp_count);
      cycles++;
      if (st == abort_st) begin
        #1 resetn = 1'b0;
        #1;
        check("abort_mem_write", mem_write, 0);
        check("abort_state", state_o, S_FETCH);
        check("abort_count", instr_count, 0);
        exp_count = 0;
        @(negedge clk);
        mem_ready = 1'b0;
        resetn = 1'b1;
        return;
      end
      if (st == S_TRAP) begin
        trap_cycles++;
        if (trap_cycles == 3) begin
          trapped = 1'b1;
          done = 1'b1;
        end
      end else if (!((st == S_FETCH || st == S_MEMREAD || st == S_MEMWRITE) && !mem_ready)) begin
        idx++;
        if (idx == seq.size()) begin
          exp_count = (exp_count + 1) & ((1 << CW) - 1);
          done = 1'b1;
        end
      end
      @(posedge clk);
    end
    if (!done) check("timeout", 0, 1);
  endtask

  logic [6:0] legal_ops[6] = '{7'b0000011, 7'b0100011, 7'b0110011,
                               7'b0010011, 7'b1101111, 7'b1100011};

  initial begin
    int cyc;
    bit trp;
    logic [6:0] opc;
    resetn = 1'b0;
    mem_ready = 1'b0;
    op = '0;
    do_reset();

    run_instr(7'b0110011, -1, cyc, trp);
    check("rtype_cycles", cyc, 4);

    ready_q = '{1'b0, 1'b0};
    run_instr(7'b0110011, -1, cyc, trp);
    check("fetch_wait_cycles", cyc, 6);

    ready_q = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    run_instr(7'b0000011, -1, cyc, trp);
    check("lw_wait_cycles", cyc, 8);

    run_instr(7'b1101111, -1, cyc, trp);
    check("jal_cycles", cyc, 4);
    run_instr(7'b0100011, -1, cyc, trp);
    check("sw_cycles", cyc, 4);
    run_instr(7'b0010011, -1, cyc, trp);
    check("itype_cycles", cyc, 4);
    run_instr(7'b1100011, -1, cyc, trp);
    check("beq_cycles", cyc, 3);
    run_instr(7'b0000011, -1, cyc, trp);
    check("lw_cycles", cyc, 5);

    run_instr(7'b1111111, -1, cyc, trp);
`ifdef MULTICYCLE_MAIN_FSM_TRAP_EN
    check("illegal_trapped", trp, 1);
`else
    check("illegal_cycles", cyc, 2);
`endif

    do_reset();
    for (int i = 0; i < 16; i++) run_instr(7'b1100011, -1, cyc, trp);
    @(negedge clk);
    mem_ready = 1'b0;
    #1;
    check("count_wrap", instr_count, 0);

    ready_q = '{1'b1, 1'b1, 1'b1, 1'b0};
    run_instr(7'b0100011, S_MEMWRITE, cyc, trp);

    rdy_random = 1'b1;
    for (int i = 0; i < 200; i++) begin
      if ($urandom_range(0, 7) == 0) opc = 7'($urandom);
      else opc = legal_ops[$urandom_range(0, 5)];
      run_instr(opc, -1, cyc, trp);
      if (trp) do_reset();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/multicycle_main_fsm.md
# multicycle_main_fsm

Main control state machine of the multi-cycle RISC-V core: decodes the 7-bit opcode from the instruction register and sequences each instruction through fetch, decode, execute, memory and writeback. It sits directly upstream of the datapath's 2:1 and 4:1 selectors, which it drives through ALUSrcA, ALUSrcB and ResultSrc. It also drives the register enables (IRWrite, PCUpdate, RegWrite, MemWrite) and keeps a retired-instruction counter. Memory accesses wait on a ready handshake.

## Interface
- COUNT_WIDTH, 32, width of the retired-instruction counter.

- clk  input  1  clock; all state changes on the rising edge.
- resetn  input  1  asynchronous, active-low reset.
- op  input  7  opcode field `instr[6:0]` from the instruction register.
- mem_ready  input  1  memory has completed the current access this cycle.
- branch  output  1  beq compare cycle; PC loads if the ALU zero flag is set, which is gated outside this block.
- pc_update  output  1  unconditional PC load.
- reg_write  output  1  register file write enable.
- mem_write  output  1  data memory write strobe.
- ir_write  output  1  instruction register load.
- adr_src  output  1  memory address select: 0 = PC, 1 = ALU result.
- alu_src_a  output  2  00 PC, 01 OldPC, 10 rs1 data.
- alu_src_b  output  2  00 rs2 data, 01 ImmExt, 10 constant 4.
- result_src  output  2  00 ALUOut, 01 Data, 10 ALUResult.
- alu_op  output  2  00 add, 01 sub (branch), 10 funct-decoded.
- illegal_instr  output  1  unknown opcode seen (see Configuration).
- state_o  output  4  current state encoding, for debug.
- instr_count  output  COUNT_WIDTH  number of retired instructions.

## Operation
- States and encodings: FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECUTER=6, EXECUTEI=7, ALUWB=8, BEQ=9, JAL=10, TRAP=11.
- Outputs are a function of the state, except the strobes qualified by mem_ready. Any output not listed for a state is 0.
- FETCH
  - Drives adr_src=0, alu_src_a=00, alu_src_b=10, alu_op=00, result_src=10.
  - ir_write and pc_update equal mem_ready.
  - Next state is DECODE if mem_ready=1; otherwise FETCH.
- DECODE: alu_src_a=01, alu_src_b=01, alu_op=00. Next state by op:
  - 0000011 or 0100011 -> MEMADR
  - 0110011 -> EXECUTER
  - 0010011 -> EXECUTEI
  - 1101111 -> JAL
  - 1100011 -> BEQ
  - any other opcode -> see Configuration.
- MEMADR: alu_src_a=10, alu_src_b=01, alu_op=00. Next is MEMREAD if op=0000011, else MEMWRITE.
- MEMREAD: adr_src=1, result_src=00. Holds until mem_ready=1, then goes to MEMWB.
- MEMWB: result_src=01, reg_write=1, then FETCH.
- MEMWRITE: adr_src=1, result_src=00, mem_write=1. Holds until mem_ready=1, then goes to FETCH.
  - mem_write stays asserted while waiting; memory samples the strobe only together with mem_ready.
- EXECUTER: alu_src_a=10, alu_src_b=00, alu_op=10, then ALUWB.
- EXECUTEI: alu_src_a=10, alu_src_b=01, alu_op=10, then ALUWB.
- ALUWB: result_src=00, reg_write=1, then FETCH.
- BEQ: alu_src_a=10, alu_src_b=00, alu_op=01, result_src=00, branch=1, then FETCH.
- JAL: alu_src_a=01, alu_src_b=10, alu_op=00, result_src=00, pc_update=1, then ALUWB.
- TRAP: illegal_instr=1; all other outputs 0. Stays in TRAP until reset.
- instr_count increments by 1 on every state register update whose next state is FETCH and whose current state is not FETCH.
  - It wraps from 2^COUNT_WIDTH−1 to 0 with no flag.
  - A transition into TRAP does not count.

## Timing
- Reset: while resetn=0, the state is FETCH and instr_count is 0.
  - All strobes (ir_write, pc_update, reg_write, mem_write, branch) are forced to 0 regardless of mem_ready.
  - The selectors show the FETCH values.
- A reset asserted mid-instruction aborts it immediately. No further strobes are issued.
- Fetch starts on the first rising edge after resetn is released.
- Cycle counts with mem_ready held at 1:
  - lw: 5 cycles
  - sw: 4 cycles
  - R-type: 4 cycles
  - I-type: 4 cycles
  - jal: 4 cycles
  - beq: 3 cycles
- Each low cycle of mem_ready in FETCH, MEMREAD or MEMWRITE adds exactly 1 cycle.
- op is sampled only in DECODE and MEMADR; changes in other states are ignored.
- ir_write and pc_update are asserted for exactly one cycle per fetch, however long the wait.

## Configuration
- MULTICYCLE_MAIN_FSM_TRAP_EN
  - Defined: an unknown opcode in DECODE moves to TRAP, which asserts illegal_instr and halts until reset.
  - Undefined: an unknown opcode returns DECODE to FETCH and counts as retired. The TRAP state is not built, and illegal_instr is tied to 0.

## Test plan
- Reset, then `op=0110011` with mem_ready=1:
  - States go FETCH, DECODE, EXECUTER, ALUWB, FETCH.
  - reg_write is high only in ALUWB.
  - instr_count becomes 1.
- lw (`op=0000011`) with mem_ready held low for 3 cycles in MEMREAD:
  - MEMREAD lasts 4 cycles, followed by MEMWB with result_src=01.
  - Total instruction time is 8 cycles.
- FETCH with mem_ready low for 2 cycles:
  - ir_write and pc_update are 0 for those 2 cycles, then high for exactly 1 cycle.
- jal (`op=1101111`):
  - JAL state shows pc_update=1, alu_src_a=01, alu_src_b=10.
  - Next state is ALUWB with reg_write=1.
- `op=1111111`:
  - With the macro defined: TRAP, illegal_instr=1, held until reset, instr_count unchanged.
  - Without the macro: back to FETCH, instr_count incremented by 1.
- Preload to 2^COUNT_WIDTH−1 by running beq loops (COUNT_WIDTH=4, 15 instructions), then retire one more: instr_count=0.
- resetn pulsed low during MEMWRITE: mem_write drops to 0 asynchronously, the state becomes FETCH, and instr_count is 0.
